// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: FSM states, word geometry, error reasons.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_OFF_W = $clog2(WORD_BYTES);

    // Error reasons; anything other than ERR_NONE raises addr_err in RESP
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_CONFLICT = 2'd2;
    localparam logic [1:0] ERR_ALIGN    = 2'd3;

endpackage

// File: rtl/mem_array.sv
// Word RAM, DEPTH x DATA_W: synchronous write, registered read with read enable, no reset.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multicycle-CPU memory responder with WAIT_CYCLES wait states and a one-cycle mem_ready pulse.
// Optional build macro MEM_ALIGN_CHECK_EN: non-word-aligned addresses become errors.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [1:0]        err_q;
    logic              zero_q, zero_d;

    logic              req, load, enter_resp;
    logic [ADDR_W-1:0] in_idx, cur_idx;
    logic [1:0]        in_err, cur_err;
    logic              cur_write;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign req    = mem_read | mem_write;
    assign in_idx = addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];

    // Later assignments win: conflict outranks range, range outranks alignment
    always_comb begin
        in_err = ERR_NONE;
`ifdef MEM_ALIGN_CHECK_EN
        if (addr[BYTE_OFF_W-1:0] != '0) in_err = ERR_ALIGN;
`endif
        if ((addr >> (ADDR_W + BYTE_OFF_W)) != '0 || 32'(in_idx) >= DEPTH) in_err = ERR_RANGE;
        if (mem_read && mem_write) in_err = ERR_CONFLICT;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // With zero wait states the request is sampled on the same edge that enters RESP
    assign cur_idx    = load ? in_idx : idx_q;
    assign cur_err    = load ? in_err : err_q;
    assign cur_write  = load ? mem_write : write_q;
    assign enter_resp = (state_d == RESP);
    assign ram_re     = enter_resp && !cur_write && (cur_err == ERR_NONE);
    assign ram_we     = (state_q == RESP) && write_q && (err_q == ERR_NONE);

    always_comb begin
        zero_d = zero_q;
        if (enter_resp) begin
            if (cur_err != ERR_NONE) zero_d = 1'b1;
            else if (!cur_write)     zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= ERR_NONE;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            if (load) begin
                idx_q   <= in_idx;
                wdata_q <= wdata;
                write_q <= mem_write;
                err_q   <= in_err;
            end
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (ram_re),
        .raddr (cur_idx),
        .rdata (ram_rdata)
    );

    // zero_q masks the RAM output after reset and on error responses
    assign rdata     = zero_q ? '0 : ram_rdata;
    assign mem_ready = (state_q == RESP);
    assign addr_err  = mem_ready && (err_q != ERR_NONE);
    assign busy      = (state_q == BUSY) || (state_q == RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        mem_ready, addr_err, busy;

    logic        mem_read0, mem_write0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        mem_ready0, addr_err0, busy0;

    int errors = 0;
    int checks = 0;

    mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .addr_err  (addr_err),
        .busy      (busy)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read0),
        .mem_write (mem_write0),
        .addr      (addr0),
        .wdata     (wdata0),
        .rdata     (rdata0),
        .mem_ready (mem_ready0),
        .addr_err  (addr_err0),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request on the main instance; lat counts negedges from the sampling edge
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd_o,
                        output logic err_o, output logic ok);
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        lat = 0; ok = 1'b0; rd_o = 'x; err_o = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (mem_ready) begin
                ok = 1'b1; rd_o = rdata; err_o = addr_err;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL timeout: no mem_ready for addr %h (got none, required one)", a);
        end
    endtask

    task automatic test_reset();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", addr_err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] r; logic e, ok;
        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, r, e, ok);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse: got %b want 0", mem_ready); end
        xact(1'b1, 1'b0, 32'h10, 32'h0, lat, r, e, ok);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", e); end
        xact(1'b0, 1'b1, 32'h44, 32'h77777777, lat, r, e, ok);
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h want deadbeef", r); end
    endtask

    task automatic test_zero_wait();
        int lat, nbusy; logic [31:0] r;
        @(negedge clk);
        mem_write0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h0BEEF010;
        @(negedge clk);
        mem_write0 = 1'b0;
        checks++; if (mem_ready0 !== 1'b1) begin errors++; $display("FAIL zw_wr_ready: got %b want 1", mem_ready0); end
        @(negedge clk);
        mem_read0 = 1'b1; addr0 = 32'h10;
        lat = 0; nbusy = 0; r = 'x;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy0) nbusy++;
            if (mem_ready0 && lat == 0) begin lat = i + 1; r = rdata0; mem_read0 = 1'b0; end
        end
        mem_read0 = 1'b0;
        checks++; if (lat !== 1) begin errors++; $display("FAIL zw_latency: got %0d want 1", lat); end
        checks++; if (r !== 32'h0BEEF010) begin errors++; $display("FAIL zw_rdata: got %h want 0beef010", r); end
        checks++; if (nbusy !== 1) begin errors++; $display("FAIL zw_busy_cycles: got %0d want 1", nbusy); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] r; logic e, ok;
        xact(1'b0, 1'b1, 32'h0, 32'h11112222, lat, r, e, ok);
        xact(1'b0, 1'b1, 32'h400, 32'h99999999, lat, r, e, ok);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err: got %b want 1", e); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", r); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_latency: got %0d want 3", lat); end
        xact(1'b1, 1'b0, 32'h0, 32'h0, lat, r, e, ok);
        checks++; if (r !== 32'h11112222) begin errors++; $display("FAIL oor_readback: got %h want 11112222", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_readback_err: got %b want 0", e); end
    endtask

    task automatic test_conflict();
        int lat; logic [31:0] r; logic e, ok;
        xact(1'b0, 1'b1, 32'h20, 32'hCAFE0020, lat, r, e, ok);
        xact(1'b1, 1'b0, 32'h20, 32'h0, lat, r, e, ok);
        xact(1'b1, 1'b1, 32'h20, 32'h55555555, lat, r, e, ok);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b want 1", e); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL conflict_rdata: got %h want 0", r); end
        xact(1'b1, 1'b0, 32'h20, 32'h0, lat, r, e, ok);
        checks++; if (r !== 32'hCAFE0020) begin errors++; $display("FAIL conflict_readback: got %h want cafe0020", r); end
    endtask

    task automatic test_reset_mid();
        int lat, seen; logic [31:0] r; logic e, ok;
        xact(1'b0, 1'b1, 32'h30, 32'h0BADF00D, lat, r, e, ok);
        xact(1'b1, 1'b0, 32'h30, 32'h0, lat, r, e, ok);
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h30; wdata = 32'h12345678;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", mem_ready); end
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_ready: got %0d pulses want 0", seen); end
        xact(1'b1, 1'b0, 32'h30, 32'h0, lat, r, e, ok);
        checks++; if (r !== 32'h0BADF00D) begin errors++; $display("FAIL rst_mid_readback: got %h want 0badf00d", r); end
    endtask

    task automatic test_align();
        int lat; logic [31:0] r, exp_word; logic e, ok, exp_err;
`ifdef MEM_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_word = 32'h01010101;
`else
        exp_err = 1'b0; exp_word = 32'hA5A5A5A5;
`endif
        xact(1'b0, 1'b1, 32'h10, 32'h01010101, lat, r, e, ok);
        xact(1'b0, 1'b1, 32'h11, 32'hA5A5A5A5, lat, r, e, ok);
        checks++; if (e !== exp_err) begin errors++; $display("FAIL align_err: got %b want %b", e, exp_err); end
        xact(1'b1, 1'b0, 32'h10, 32'h0, lat, r, e, ok);
        checks++; if (r !== exp_word) begin errors++; $display("FAIL align_word4: got %h want %h", r, exp_word); end
    endtask

    task automatic test_back_to_back();
        int first, second, n;
        @(negedge clk);
        mem_read = 1'b1; addr = 32'h20;
        first = -1; second = -1; n = 0;
        for (int i = 0; i < 20 && second < 0; i++) begin
            @(negedge clk);
            n++;
            if (mem_ready) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        mem_read = 1'b0;
        checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first: got %0d want 3", first); end
        checks++; if (second - first !== 4) begin errors++; $display("FAIL b2b_gap: got %0d want 4", second - first); end
        checks++; if (rdata !== 32'hCAFE0020) begin errors++; $display("FAIL b2b_rdata: got %h want cafe0020", rdata); end
    endtask

    initial begin
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        mem_read0 = 1'b0; mem_write0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_write_read();
        test_zero_wait();
        test_out_of_range();
        test_conflict();
        test_reset_mid();
        test_align();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
